// File: rtl/decode_stage.sv
// decode_stage
// ------------
// Instruction-decode stage of the 5-stage MIPS pipeline. It holds the 32x32
// register file (written from write-back), decodes one instruction per cycle
// into the D/X pipeline registers, and stalls fetch for one cycle on a
// load-use hazard by loading a bubble into D/X.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   FD_IR, FD_PC      instruction from fetch and its address
//   flush             squash the instruction currently in decode
//   WB_RegWrite/RD/Data  register-file write port from write-back
//   stall             combinational; fetch must hold FD_IR/FD_PC
//   A, B, ALUctr      ALU operands and operation for EX
//   DX_RD, DX_RegWrite   destination register and its write enable
//   DX_Branch, DX_BranchTarget  beq flag and its target address
//   DX_MemRead, DX_MemWrite, DX_StoreData  memory-stage controls (lw/sw)

module decode_stage #(
   parameter int NREG = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] FD_IR,
   input  logic [31:0] FD_PC,
   input  logic        flush,
   input  logic        WB_RegWrite,
   input  logic [4:0]  WB_RD,
   input  logic [31:0] WB_Data,
   output logic        stall,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [4:0]  DX_RD,
   output logic [2:0]  ALUctr,
   output logic        DX_Branch,
   output logic        DX_RegWrite,
   output logic        DX_MemRead,
   output logic        DX_MemWrite,
   output logic [31:0] DX_StoreData,
   output logic [31:0] DX_BranchTarget
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Instruction fields
   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  funct;
   logic [31:0] sext;
   logic        unused_shamt;

   assign op           = FD_IR[31:26];
   assign rs           = FD_IR[25:21];
   assign rt           = FD_IR[20:16];
   assign rd           = FD_IR[15:11];
   assign funct        = FD_IR[5:0];
   assign sext         = {{16{FD_IR[15]}}, FD_IR[15:0]};
   assign unused_shamt = ^FD_IR[10:6];

   // Register file
   logic [31:0] regs_q [NREG];
   logic [31:0] regs_d [NREG];
   logic        wb_active;
   logic [31:0] rs_val;
   logic [31:0] rt_val;

   assign wb_active = WB_RegWrite && (WB_RD != 5'd0);

   always_comb begin
      regs_d = regs_q;
      if (wb_active) begin
         regs_d[WB_RD] = WB_Data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Write-through lets a value retiring in write-back this cycle reach the
   // instruction being decoded without an extra forwarding path in EX.
   always_comb begin
      rs_val = regs_q[rs];
      rt_val = regs_q[rt];
      if (rs == 5'd0) begin
         rs_val = '0;
      end else if (wb_active && (WB_RD == rs)) begin
         rs_val = WB_Data;
      end
      if (rt == 5'd0) begin
         rt_val = '0;
      end else if (wb_active && (WB_RD == rt)) begin
         rt_val = WB_Data;
      end
   end

   // D/X pipeline registers
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [4:0]  dx_rd_q, dx_rd_d;
   logic [2:0]  alu_ctr_q, alu_ctr_d;
   logic        dx_branch_q, dx_branch_d;
   logic        dx_reg_write_q, dx_reg_write_d;
   logic        dx_mem_read_q, dx_mem_read_d;
   logic        dx_mem_write_q, dx_mem_write_d;
   logic [31:0] dx_store_data_q, dx_store_data_d;
   logic [31:0] dx_branch_target_q, dx_branch_target_d;

   // Load-use hazard: the load in EX has not produced its data yet. rt only
   // counts as a source for instructions that actually read it.
   logic uses_rt;
   logic hazard;

   assign uses_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
   assign hazard  = dx_mem_read_q && (dx_rd_q != 5'd0) &&
                    ((dx_rd_q == rs) || ((dx_rd_q == rt) && uses_rt));
   assign stall   = !rst && hazard;

   // Decode into the next D/X contents. Everything starts as a bubble; only a
   // recognised instruction that is neither flushed nor stalled overrides it.
   always_comb begin
      a_d                = '0;
      b_d                = '0;
      dx_rd_d            = '0;
      alu_ctr_d          = ALU_ADD;
      dx_branch_d        = 1'b0;
      dx_reg_write_d     = 1'b0;
      dx_mem_read_d      = 1'b0;
      dx_mem_write_d     = 1'b0;
      dx_store_data_d    = '0;
      dx_branch_target_d = '0;

      if (!flush && !hazard) begin
         unique case (op)
            OP_RTYPE: begin
               // funct 000000 (sll, including the all-zero nop) is not
               // in this list, so it falls through as a bubble.
               if ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                   (funct == FN_OR)  || (funct == FN_SLT)) begin
                  a_d            = rs_val;
                  b_d            = rt_val;
                  dx_rd_d        = rd;
                  dx_reg_write_d = 1'b1;
                  unique case (funct)
                     FN_SUB:  alu_ctr_d = ALU_SUB;
                     FN_AND:  alu_ctr_d = ALU_AND;
                     FN_OR:   alu_ctr_d = ALU_OR;
                     FN_SLT:  alu_ctr_d = ALU_SLT;
                     default: alu_ctr_d = ALU_ADD;
                  endcase
               end
            end
            OP_ADDI, OP_LW: begin
               a_d            = rs_val;
               b_d            = sext;
               dx_rd_d        = rt;
               dx_reg_write_d = 1'b1;
               dx_mem_read_d  = (op == OP_LW);
            end
            OP_SW: begin
               a_d             = rs_val;
               b_d             = sext;
               dx_store_data_d = rt_val;
               dx_mem_write_d  = 1'b1;
            end
            OP_BEQ: begin
               a_d                = rs_val;
               b_d                = rt_val;
               alu_ctr_d          = ALU_SUB;
               dx_branch_d        = 1'b1;
               dx_branch_target_d = FD_PC + 32'd4 + {sext[29:0], 2'b00};
            end
            default: begin
            end
         endcase
      end
   end

   // Reset value of ALUctr is 000, distinct from the bubble's 010.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q                <= '0;
         b_q                <= '0;
         dx_rd_q            <= '0;
         alu_ctr_q          <= '0;
         dx_branch_q        <= 1'b0;
         dx_reg_write_q     <= 1'b0;
         dx_mem_read_q      <= 1'b0;
         dx_mem_write_q     <= 1'b0;
         dx_store_data_q    <= '0;
         dx_branch_target_q <= '0;
      end else begin
         a_q                <= a_d;
         b_q                <= b_d;
         dx_rd_q            <= dx_rd_d;
         alu_ctr_q          <= alu_ctr_d;
         dx_branch_q        <= dx_branch_d;
         dx_reg_write_q     <= dx_reg_write_d;
         dx_mem_read_q      <= dx_mem_read_d;
         dx_mem_write_q     <= dx_mem_write_d;
         dx_store_data_q    <= dx_store_data_d;
         dx_branch_target_q <= dx_branch_target_d;
      end
   end

   assign A               = a_q;
   assign B               = b_q;
   assign DX_RD           = dx_rd_q;
   assign ALUctr          = alu_ctr_q;
   assign DX_Branch       = dx_branch_q;
   assign DX_RegWrite     = dx_reg_write_q;
   assign DX_MemRead      = dx_mem_read_q;
   assign DX_MemWrite     = dx_mem_write_q;
   assign DX_StoreData    = dx_store_data_q;
   assign DX_BranchTarget = dx_branch_target_q;

endmodule
